cdf_sequencer: RTL and testbench
================================

CDF_SEQUENCER -- requirements
Module: cdf_sequencer

Interface
REQ-001 Parameter TIMEOUT, default 512: maximum RUN cycles allowed before a pass is aborted.
REQ-002 Parameter GAP, default 2: number of SETUP cycles with fetch_start low before each pass, minimum 1.
REQ-003 Port clock, input, 1: the single clock; all logic is on the rising edge.
REQ-004 Port reset_n, input, 1: reset is synchronous and active-low.
REQ-005 Port req_valid, input, 1: a requester is asking for a CDF pass.
REQ-006 Port req_bank, input, 1: image bank for the requested pass.
REQ-007 Port req_ready, output, 1: a request can be accepted this cycle.
REQ-008 Port fetch_start, output, 1: start signal for the CDF fetch stage.
REQ-009 Port fetch_base, output, 1: drives the fetch stage input_base_offset.
REQ-010 Port fetch_addr, input, 16: the fetch stage read address.
REQ-011 Port fetch_done, input, 1: done from the fetch stage; level, high until start drops.
REQ-012 Port host_rd_en, input, 1: host read request.
REQ-013 Port host_rd_addr, input, 16: host read address.
REQ-014 Port host_rd_grant, output, 1: the host read is being served this cycle.
REQ-015 Port mem_addr, output, 16: address to the shared 36-bit read memory.
REQ-016 Port busy, output, 1: the sequencer is not IDLE.
REQ-017 Port pass_done, output, 1: one-cycle pulse marking the end of a pass.
REQ-018 Port pass_bank, output, 1: bank of the pass just ended, valid with pass_done.
REQ-019 Port timeout_err, output, 1: sticky flag set when any pass timed out.
REQ-020 Port pass_count, output, 8: count of passes completed without timeout.

Function
REQ-021 The FSM SHALL have states IDLE, SETUP, RUN and FINISH.
REQ-022 Handshake: a request SHALL be accepted on req_valid & req_ready; req_ready is high whenever the one-entry pending slot is empty.
REQ-023 From IDLE, an accepted request SHALL bypass the slot: latch req_bank into cur_bank and go to SETUP on the next cycle.
REQ-024 In any other state, an accepted request SHALL load the pending slot.
REQ-025 SETUP SHALL hold fetch_start=0 and fetch_base=cur_bank for exactly GAP cycles, then go to RUN.
REQ-026 RUN SHALL hold fetch_start=1 and fetch_base=cur_bank, and increment a timer that is cleared on entry to RUN.
REQ-027 RUN SHALL go to FINISH on the first cycle fetch_done=1; fetch_start SHALL be 0 in the following cycle.
REQ-028 If the RUN timer reaches TIMEOUT while fetch_done=0, the sequencer SHALL set timeout_err and go to FINISH.
REQ-029 If fetch_done and the timeout occur in the same cycle, fetch_done SHALL win and no error is set.
REQ-030 FINISH SHALL last 1 cycle with pass_done=1, pass_bank=cur_bank and fetch_start=0.
REQ-031 On exit from FINISH, a full slot SHALL move to cur_bank, empty itself and go to SETUP; an empty slot SHALL lead to IDLE.
REQ-032 A request accepted in FINISH SHALL be loaded into the slot and SHALL be served immediately at the FINISH exit.
REQ-033 pass_count SHALL increment in FINISH only for passes that did not time out, and SHALL wrap from 255 to 0.
REQ-034 Arbitration in RUN: mem_addr = fetch_addr and host_rd_grant = 0.
REQ-035 Arbitration in all other states: mem_addr = host_rd_addr and host_rd_grant = host_rd_en.
REQ-036 Arbitration SHALL be combinational from the registered state.
REQ-037 busy SHALL be high whenever state ≠ IDLE.
REQ-038 Nominal latency: request accepted in IDLE at cycle 0, SETUP at cycles 1..GAP, RUN from cycle GAP+1, pass_done one cycle after fetch_done is first seen.

Reset
REQ-039 While reset_n=0 at a clock edge: state IDLE, pending slot empty, cur_bank 0, timer 0, pass_count 0, timeout_err 0.
REQ-040 All registered outputs SHALL be 0 after reset; req_ready SHALL be 1.
REQ-041 Reset asserted mid-RUN SHALL force fetch_start=0 on the next cycle, with no pass_done pulse and no pass_count change.

Structure
REQ-042 Shared package cdf_pkg SHALL hold the state enum, the TIMEOUT and GAP defaults, and the 16'haaaa data tag constant.
REQ-043 The address/grant mux SHALL be a sub-module, cdf_rd_arb, with inputs state, fetch_addr and the host signals.

Verification
REQ-044 Single pass: reset, then req_valid=1 with bank=1 for 1 cycle, fetch model asserts done 258 cycles into RUN -> fetch_start high for 258 cycles, fetch_base=1, then pass_done=1, pass_bank=1 and pass_count=1.
REQ-045 Queued pass: second request with bank=0 during RUN -> req_ready drops after acceptance; the second pass runs with fetch_start low for exactly GAP=2 cycles between passes; pass_count=2.
REQ-046 Timeout: fetch model never asserts done -> after 512 RUN cycles timeout_err=1, pass_done pulses, pass_count unchanged, and timeout_err stays set through a subsequent good pass.
REQ-047 Arbitration: host_rd_en=1 with addr 0x1234 during SETUP, then RUN -> mem_addr=0x1234 with grant=1 in SETUP; mem_addr=fetch_addr with grant=0 in RUN.
REQ-048 Reset mid-RUN at cycle 100 -> next cycle fetch_start=0, busy=0, no pass_done pulse.
REQ-049 Wrap and collision: run 256 good passes -> pass_count wraps to 0; fetch_done asserted in the same cycle the timer reaches TIMEOUT -> no error is set.

Source files
------------

// File: rtl/cdf_pkg.sv
// rtl/cdf_pkg.sv - shared state encoding and defaults for the CDF pass sequencer
package cdf_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_RUN    = 2'd2,
    ST_FINISH = 2'd3
  } cdf_state_e;

  localparam int          CDF_TIMEOUT_DEF = 512;
  localparam int          CDF_GAP_DEF     = 2;
  localparam logic [15:0] CDF_DATA_TAG    = 16'haaaa;

endpackage

// File: rtl/cdf_rd_arb.sv
// rtl/cdf_rd_arb.sv - shared read-memory address mux: fetch stage owns the port in RUN,
// the host owns it otherwise
module cdf_rd_arb
  import cdf_pkg::*;
(
  input  logic [1:0]  state_i,
  input  logic [15:0] fetch_addr_i,
  input  logic        host_rd_en_i,
  input  logic [15:0] host_rd_addr_i,
  output logic [15:0] mem_addr_o,
  output logic        host_rd_grant_o
);

  always_comb begin
    mem_addr_o      = host_rd_addr_i;
    host_rd_grant_o = host_rd_en_i;
    if (state_i == ST_RUN) begin
      mem_addr_o      = fetch_addr_i;
      host_rd_grant_o = 1'b0;
    end
  end

endmodule

// File: rtl/cdf_sequencer.sv
// rtl/cdf_sequencer.sv - sequences CDF fetch passes with a one-entry request slot,
// a RUN watchdog and pass bookkeeping
module cdf_sequencer
  import cdf_pkg::*;
#(
  parameter int TIMEOUT = CDF_TIMEOUT_DEF,
  parameter int GAP     = CDF_GAP_DEF
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req_valid,
  input  logic        req_bank,
  output logic        req_ready,
  output logic        fetch_start,
  output logic        fetch_base,
  input  logic [15:0] fetch_addr,
  input  logic        fetch_done,
  input  logic        host_rd_en,
  input  logic [15:0] host_rd_addr,
  output logic        host_rd_grant,
  output logic [15:0] mem_addr,
  output logic        busy,
  output logic        pass_done,
  output logic        pass_bank,
  output logic        timeout_err,
  output logic [7:0]  pass_count
);

  localparam int            TMAX       = (TIMEOUT > GAP) ? TIMEOUT : GAP;
  localparam int            TW         = $clog2(TMAX + 1);
  localparam logic [TW-1:0] RUN_LAST   = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] SETUP_LAST = TW'(GAP - 1);

  cdf_state_e    state_q, state_d;
  logic          cur_bank_q, cur_bank_d;
  logic          slot_full_q, slot_full_d;
  logic          slot_bank_q, slot_bank_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          pass_to_q, pass_to_d;
  logic          timeout_err_q, timeout_err_d;
  logic [7:0]    pass_count_q, pass_count_d;

  logic accept;
  logic run_to;

  assign accept = req_valid & ~slot_full_q;
  assign run_to = (state_q == ST_RUN) & ~fetch_done & (timer_q == RUN_LAST);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (accept) state_d = ST_SETUP;
      ST_SETUP:  if (timer_q == SETUP_LAST) state_d = ST_RUN;
      ST_RUN:    if (fetch_done || timer_q == RUN_LAST) state_d = ST_FINISH;
      ST_FINISH: state_d = (slot_full_q || accept) ? ST_SETUP : ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy        = 1'b0;
    fetch_start = 1'b0;
    pass_done   = 1'b0;
    busy        = (state_q != ST_IDLE);
    fetch_start = (state_q == ST_RUN);
    pass_done   = (state_q == ST_FINISH);
  end

  assign req_ready   = ~slot_full_q;
  assign fetch_base  = cur_bank_q;
  assign pass_bank   = pass_done & cur_bank_q;
  assign timeout_err = timeout_err_q;
  assign pass_count  = pass_count_q;

  always_comb begin
    cur_bank_d    = cur_bank_q;
    slot_full_d   = slot_full_q;
    slot_bank_d   = slot_bank_q;
    pass_to_d     = pass_to_q;
    timeout_err_d = timeout_err_q;
    pass_count_d  = pass_count_q;
    timer_d       = (state_d != state_q || state_q == ST_IDLE) ? '0 : timer_q + 1'b1;

    // A request arriving in FINISH passes straight through the (empty) slot to the next pass.
    if (accept) begin
      if (state_q == ST_IDLE || state_q == ST_FINISH) begin
        cur_bank_d = req_bank;
      end else begin
        slot_full_d = 1'b1;
        slot_bank_d = req_bank;
      end
    end
    if (state_q == ST_FINISH && slot_full_q) begin
      cur_bank_d  = slot_bank_q;
      slot_full_d = 1'b0;
    end

    // fetch_done beats the watchdog when both land on the last RUN cycle.
    if (state_q == ST_RUN && fetch_done) begin
      pass_to_d = 1'b0;
    end else if (run_to) begin
      pass_to_d     = 1'b1;
      timeout_err_d = 1'b1;
    end
    if (state_q == ST_FINISH && !pass_to_q) begin
      pass_count_d = pass_count_q + 8'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      cur_bank_q    <= 1'b0;
      slot_full_q   <= 1'b0;
      slot_bank_q   <= 1'b0;
      timer_q       <= '0;
      pass_to_q     <= 1'b0;
      timeout_err_q <= 1'b0;
      pass_count_q  <= 8'd0;
    end else begin
      cur_bank_q    <= cur_bank_d;
      slot_full_q   <= slot_full_d;
      slot_bank_q   <= slot_bank_d;
      timer_q       <= timer_d;
      pass_to_q     <= pass_to_d;
      timeout_err_q <= timeout_err_d;
      pass_count_q  <= pass_count_d;
    end
  end

  cdf_rd_arb u_rd_arb (
    .state_i         (state_q),
    .fetch_addr_i    (fetch_addr),
    .host_rd_en_i    (host_rd_en),
    .host_rd_addr_i  (host_rd_addr),
    .mem_addr_o      (mem_addr),
    .host_rd_grant_o (host_rd_grant)
  );

endmodule

// File: tb/tb_cdf_sequencer.sv
// tb/tb_cdf_sequencer.sv - scoreboard bench for cdf_sequencer with a behavioural fetch model
module tb_cdf_sequencer;
  import cdf_pkg::*;

  localparam int TO    = 512;
  localparam int GP    = 2;
  localparam int NEVER = 100000;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_bank = 1'b0;
  logic        req_ready;
  logic        fetch_start;
  logic        fetch_base;
  logic [15:0] fetch_addr = 16'h0;
  logic        fetch_done = 1'b0;
  logic        host_rd_en = 1'b0;
  logic [15:0] host_rd_addr = 16'h0;
  logic        host_rd_grant;
  logic [15:0] mem_addr;
  logic        busy;
  logic        pass_done;
  logic        pass_bank;
  logic        timeout_err;
  logic [7:0]  pass_count;

  cdf_sequencer #(.TIMEOUT(TO), .GAP(GP)) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .req_valid     (req_valid),
    .req_bank      (req_bank),
    .req_ready     (req_ready),
    .fetch_start   (fetch_start),
    .fetch_base    (fetch_base),
    .fetch_addr    (fetch_addr),
    .fetch_done    (fetch_done),
    .host_rd_en    (host_rd_en),
    .host_rd_addr  (host_rd_addr),
    .host_rd_grant (host_rd_grant),
    .mem_addr      (mem_addr),
    .busy          (busy),
    .pass_done     (pass_done),
    .pass_bank     (pass_bank),
    .timeout_err   (timeout_err),
    .pass_count    (pass_count)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  typedef struct {
    logic       bank;
    int         run;
    logic [7:0] cnt;
    logic       err;
  } pass_t;

  pass_t      exp_q[$];
  int         delay_q[$];
  logic [7:0] m_cnt = 8'd0;
  logic       m_err = 1'b0;
  bit         mon_en = 1'b1;

  // Fetch stage model: raises done after the chosen number of start-high cycles.
  bit f_active = 1'b0;
  int f_n = 0;
  int f_d = 1;
  always @(negedge clock) begin
    if (fetch_start) begin
      if (!f_active) begin
        f_active = 1'b1;
        f_n = 0;
        if (delay_q.size() != 0) f_d = delay_q.pop_front();
        else begin
          chk("fetch_delay_available", 32'd0, 32'd1);
          f_d = 1;
        end
      end
      f_n++;
      if (f_n >= f_d) fetch_done = 1'b1;
    end else begin
      f_active = 1'b0;
      fetch_done = 1'b0;
    end
  end

  always @(posedge clock) begin
    #1;
    host_rd_en   = 1'($urandom_range(0, 1));
    host_rd_addr = ($urandom_range(0, 3) == 0) ? 16'h1234 : 16'($urandom);
    fetch_addr   = CDF_DATA_TAG ^ {8'h00, 8'($urandom)};
  end

  always @(negedge clock) begin
    if (fetch_start) begin
      chk("arb_run_addr", 32'(mem_addr), 32'(fetch_addr));
      chk("arb_run_grant", 32'(host_rd_grant), 32'd0);
    end else begin
      chk("arb_host_addr", 32'(mem_addr), 32'(host_rd_addr));
      chk("arb_host_grant", 32'(host_rd_grant), 32'(host_rd_en));
    end
  end

  int         setup_len = 0;
  int         run_len = 0;
  logic       run_base = 1'b0;
  bit         cnt_chk = 1'b0;
  logic [7:0] cnt_exp = 8'd0;
  bit         prev_fs = 1'b0;
  always @(negedge clock) begin
    pass_t e;
    if (!mon_en) begin
      setup_len = 0;
      run_len   = 0;
      cnt_chk   = 1'b0;
      prev_fs   = 1'b0;
    end else begin
      if (cnt_chk) begin
        chk("pass_count", 32'(pass_count), 32'(cnt_exp));
        cnt_chk = 1'b0;
      end
      if (fetch_start) begin
        if (!prev_fs) begin
          chk("setup_gap", 32'(setup_len), 32'(GP));
          setup_len = 0;
          run_base  = fetch_base;
        end
        run_len++;
      end else if (busy && !pass_done) begin
        setup_len++;
      end
      if (pass_done) begin
        if (exp_q.size() == 0) chk("unexpected_pass_done", 32'd1, 32'd0);
        else begin
          e = exp_q.pop_front();
          chk("pass_bank", 32'(pass_bank), 32'(e.bank));
          chk("run_fetch_base", 32'(run_base), 32'(e.bank));
          chk("run_length", 32'(run_len), 32'(e.run));
          chk("timeout_err", 32'(timeout_err), 32'(e.err));
          cnt_exp = e.cnt;
          cnt_chk = 1'b1;
        end
        run_len = 0;
      end
      prev_fs = fetch_start;
    end
  end

  task automatic send(input logic bank, input int d);
    int    n = 0;
    pass_t e;
    @(posedge clock);
    #1;
    req_valid = 1'b1;
    req_bank  = bank;
    forever begin
      @(negedge clock);
      if (req_ready) break;
      n++;
      if (n > 2000) begin
        chk("req_accept_timeout", 32'd0, 32'd1);
        req_valid = 1'b0;
        return;
      end
    end
    e.bank = bank;
    e.run  = (d > TO) ? TO : d;
    if (d <= TO) m_cnt = m_cnt + 8'd1;
    if (d > TO) m_err = 1'b1;
    e.cnt  = m_cnt;
    e.err  = m_err;
    exp_q.push_back(e);
    delay_q.push_back(d);
    @(posedge clock);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((busy || exp_q.size() != 0) && n < budget) begin
      @(negedge clock);
      n++;
    end
    if (n >= budget) chk("idle_wait_expired", 32'd0, 32'd1);
    repeat (2) @(negedge clock);
  endtask

  task automatic wait_fs(input int budget);
    int n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!fetch_start && n < budget);
    if (!fetch_start) chk("run_wait_expired", 32'd0, 32'd1);
  endtask

  initial begin
    repeat (3) @(negedge clock);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_fetch_start", 32'(fetch_start), 32'd0);
    chk("rst_fetch_base", 32'(fetch_base), 32'd0);
    chk("rst_pass_done", 32'(pass_done), 32'd0);
    chk("rst_pass_bank", 32'(pass_bank), 32'd0);
    chk("rst_timeout_err", 32'(timeout_err), 32'd0);
    chk("rst_pass_count", 32'(pass_count), 32'd0);
    reset_n = 1'b1;

    send(1'b1, 258);
    wait_idle(2000);

    send(1'b1, 300);
    wait_fs(100);
    send(1'b0, 100);
    @(negedge clock);
    chk("req_ready_slot_full", 32'(req_ready), 32'd0);
    wait_idle(3000);

    send(1'b1, TO);
    wait_idle(2000);

    send(1'b0, NEVER);
    send(1'b1, 50);
    wait_idle(3000);

    for (int i = 0; i < 300; i++) begin
      repeat ($urandom_range(0, 8)) @(posedge clock);
      send(1'($urandom_range(0, 1)),
           ($urandom_range(0, 19) == 0) ? int'($urandom_range(TO - 1, TO + 1))
                                        : int'($urandom_range(1, 8)));
    end
    wait_idle(20000);

    send(1'b1, NEVER);
    wait_fs(100);
    repeat (99) @(negedge clock);
    mon_en  = 1'b0;
    reset_n = 1'b0;
    @(negedge clock);
    chk("midrun_rst_fetch_start", 32'(fetch_start), 32'd0);
    chk("midrun_rst_busy", 32'(busy), 32'd0);
    chk("midrun_rst_pass_done", 32'(pass_done), 32'd0);
    chk("midrun_rst_timeout_err", 32'(timeout_err), 32'd0);
    reset_n = 1'b1;
    delay_q.delete();
    exp_q.delete();
    m_cnt = 8'd0;
    m_err = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      chk("no_pass_after_reset", 32'(pass_done), 32'd0);
    end
    mon_en = 1'b1;
    send(1'b0, 5);
    wait_idle(200);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
